pw_conv_top: RTL and testbench
==============================

PW_CONV_TOP -- requirements
Module: pw_conv_top

Interface
REQ-001 Parameters (name, default, meaning): DATA_W 8 pixel width; FILTER_W 8 weight width; BIAS_W 16 bias width; PIXEL_ROW 18 rows per tile; PIXEL_COL 2 columns per tile; INPUT_NUM 36 pixels per input channel (PIXEL_ROW*PIXEL_COL); OUTPUT_NUM 36 pixels per output channel; CH_NUM 32 input channels; OUT_CH_NUM 32 output channels per job; OUT_SHIFT 7 requantization right shift.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- pwconv_valid_i, in, 1, job start pulse.
- pwconv_pixel_i, in, DATA_W*INPUT_NUM*CH_NUM, input tile.
- pwconv_weight_i, in, CH_NUM*FILTER_W, one output filter.
- pwconv_bias_i, in, BIAS_W, bias of that filter.
- pwconv_pixel_o, out, DATA_W*OUTPUT_NUM, one output channel.
- pwconv_valid_o, out, 1, output channel valid.
REQ-003 Pixel packing: channel c, pixel p at bits [(c*INPUT_NUM+p)*DATA_W +: DATA_W], where p = row*PIXEL_COL+col.
REQ-004 Weight packing: weight for input channel c at [c*FILTER_W +: FILTER_W].
REQ-005 Output packing: pixel p at [p*DATA_W +: DATA_W].
REQ-006 Pixels, weights, bias and outputs are signed two's complement.

Function
REQ-007 States: IDLE and BUSY; pwconv_valid_i high in IDLE at edge T0 enters BUSY; pwconv_valid_i in BUSY is ignored.
REQ-008 At T0 the whole pwconv_pixel_i is latched; this copy is used for the entire job.
REQ-009 Output channel k (k = 0..OUT_CH_NUM-1) latches pwconv_weight_i and pwconv_bias_i at edge T0+18k (PIXEL_ROW cycles per channel); inputs at other edges are don't-care.
REQ-010 At edges T0+18k+1+r (r = 0..PIXEL_ROW-1) the PIXEL_COL pixels of row r are computed in parallel and stored into an internal staging buffer.
REQ-011 Per pixel p: acc = sum over c of pixel[c][p]*weight[c] + sign-extended bias; acc is full precision (at least 24 bits, no overflow).
REQ-012 Result = acc arithmetic-shifted right by OUT_SHIFT, then saturated to [-128, 127] (DATA_W bits).
REQ-013 At edge T0+18k+19 the complete staging buffer is copied to pwconv_pixel_o and pwconv_valid_o rises for exactly one cycle.
REQ-014 Valid pulses occur OUT_CH_NUM times, spaced PIXEL_ROW cycles apart, for channels k = 0..OUT_CH_NUM-1 in order.
REQ-015 pwconv_pixel_o holds its value until the next update.
REQ-016 After the last channel's pulse the block returns to IDLE.
REQ-017 A new pwconv_valid_i is accepted from the cycle after the return to IDLE.
REQ-018 Row counter wraps 17->0 and channel counter wraps OUT_CH_NUM-1->0 at channel/job boundaries; no state leaks between jobs.

Reset
REQ-019 rst_n low immediately (asynchronously) clears pwconv_valid_o, pwconv_pixel_o, staging buffer, counters, and latched weight/bias/pixels to 0, and forces IDLE.
REQ-020 Reset asserted mid-job aborts the job with no further valid pulses; after release the block waits for a new pwconv_valid_i.

Verification
REQ-021 Reset, then no pwconv_valid_i for 100 cycles -> pwconv_valid_o=0 and pwconv_pixel_o=0 throughout.
REQ-022 All pixels 4, all weights 1, bias 0 -> 32 pulses, first at T0+19, then every 18 cycles; every output byte = 1 (128>>7).
REQ-023 Pixels 127, weights 127 -> all outputs 127 (saturated); same pixels with weights -128 -> all outputs 0x80 (-128).
REQ-024 Weights 0: bias 640 -> outputs 5; bias -1 -> outputs 0xFF (-1).
REQ-025 Pixel p = p in every channel, weights 1, bias 0 -> output byte p = p/4 (floor); checks pixel packing.
REQ-026 Weight bus = k for channel k, plus a second pwconv_valid_i pulse mid-job -> pulse k outputs min(32*k*pixel>>7, 127), the extra pulse is ignored; rst_n asserted mid-job -> outputs clear immediately and no further pulses.

Source files
------------

// File: rtl/pw_conv_top.sv
// Pointwise (1x1) conv: one latched tile x OUT_CH_NUM filters, one output channel per PIXEL_ROW cycles.
// First pwconv_valid_o PIXEL_ROW+1 cycles after start; no backpressure, pwconv_valid_i ignored while busy.
module pw_conv_top #(
  parameter int DATA_W     = 8,
  parameter int FILTER_W   = 8,
  parameter int BIAS_W     = 16,
  parameter int PIXEL_ROW  = 18,
  parameter int PIXEL_COL  = 2,
  parameter int INPUT_NUM  = 36,
  parameter int OUTPUT_NUM = 36,
  parameter int CH_NUM     = 32,
  parameter int OUT_CH_NUM = 32,
  parameter int OUT_SHIFT  = 7
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pwconv_valid_i,
  input  logic [DATA_W*INPUT_NUM*CH_NUM-1:0] pwconv_pixel_i,
  input  logic [CH_NUM*FILTER_W-1:0]         pwconv_weight_i,
  input  logic [BIAS_W-1:0]                  pwconv_bias_i,
  output logic [DATA_W*OUTPUT_NUM-1:0]       pwconv_pixel_o,
  output logic                               pwconv_valid_o
);

  localparam int ACC_W = 32;
  localparam int RW    = $clog2(PIXEL_ROW + 1);
  localparam int CW    = $clog2(OUT_CH_NUM + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;

  logic [DATA_W*INPUT_NUM*CH_NUM-1:0] pix_q;
  logic [CH_NUM*FILTER_W-1:0]         weight_q;
  logic [BIAS_W-1:0]                  bias_q;
  logic [DATA_W*OUTPUT_NUM-1:0]       staging;
  logic [RW-1:0]                      row_cnt;
  logic [CW-1:0]                      ch_cnt;
  logic                               out_pend;
  logic                               last_flush;
  logic                               compute_en;
  logic                               row_last;
  logic                               ch_last;

  logic signed [ACC_W-1:0] acc [PIXEL_COL];
  logic signed [ACC_W-1:0] shv [PIXEL_COL];
  logic [DATA_W-1:0]       row_res [PIXEL_COL];

  // The flush edge of the final channel is the only pending copy seen with ch_cnt already wrapped to 0.
  assign last_flush = out_pend && (ch_cnt == '0);
  assign compute_en = (state == BUSY) && !last_flush;
  assign row_last   = (row_cnt == RW'(PIXEL_ROW - 1));
  assign ch_last    = (ch_cnt == CW'(OUT_CH_NUM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pwconv_valid_i) state_nxt = BUSY;
      BUSY: if (last_flush)     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int j = 0; j < PIXEL_COL; j++) begin
      acc[j] = ACC_W'($signed(bias_q));
      for (int c = 0; c < CH_NUM; c++) begin
        acc[j] = acc[j]
               + ACC_W'($signed(pix_q[(c*INPUT_NUM + int'(row_cnt)*PIXEL_COL + j)*DATA_W +: DATA_W]))
               * ACC_W'($signed(weight_q[c*FILTER_W +: FILTER_W]));
      end
      shv[j] = acc[j] >>> OUT_SHIFT;
      if (shv[j] > SAT_MAX)      row_res[j] = SAT_MAX[DATA_W-1:0];
      else if (shv[j] < SAT_MIN) row_res[j] = SAT_MIN[DATA_W-1:0];
      else                       row_res[j] = shv[j][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q          <= '0;
      weight_q       <= '0;
      bias_q         <= '0;
      staging        <= '0;
      row_cnt        <= '0;
      ch_cnt         <= '0;
      out_pend       <= 1'b0;
      pwconv_pixel_o <= '0;
      pwconv_valid_o <= 1'b0;
    end else begin
      pwconv_valid_o <= 1'b0;
      out_pend       <= 1'b0;
      if (state == IDLE && pwconv_valid_i) begin
        pix_q    <= pwconv_pixel_i;
        weight_q <= pwconv_weight_i;
        bias_q   <= pwconv_bias_i;
        row_cnt  <= '0;
        ch_cnt   <= '0;
      end
      if (out_pend) begin
        pwconv_pixel_o <= staging;
        pwconv_valid_o <= 1'b1;
      end
      if (compute_en) begin
        for (int j = 0; j < PIXEL_COL; j++)
          staging[(int'(row_cnt)*PIXEL_COL + j)*DATA_W +: DATA_W] <= row_res[j];
        if (row_last) begin
          row_cnt  <= '0;
          out_pend <= 1'b1;
          // Row 17 still uses the old filter; the next filter lands on this same edge.
          if (ch_last) begin
            ch_cnt <= '0;
          end else begin
            ch_cnt   <= ch_cnt + 1'b1;
            weight_q <= pwconv_weight_i;
            bias_q   <= pwconv_bias_i;
          end
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pw_conv_top.sv
// Randomized and directed jobs for pw_conv_top checked against a per-pixel arithmetic reference model.
module tb_pw_conv_top;

  localparam int NP     = 36;
  localparam int CH     = 32;
  localparam int OCH    = 32;
  localparam int PIX_BW = 8 * NP * CH;
  localparam int W_BW   = 8 * CH;
  localparam int OUT_BW = 8 * NP;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_i;
  logic [PIX_BW-1:0] pixel_i;
  logic [W_BW-1:0]   weight_i;
  logic [15:0]       bias_i;
  logic [OUT_BW-1:0] pixel_o;
  logic              valid_o;

  int checks = 0;
  int errors = 0;

  int pix_m [CH][NP];
  int w_m   [OCH][CH];
  int b_m   [OCH];
  logic [OUT_BW-1:0] exp_hold;

  always #5 clk = ~clk;

  pw_conv_top dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pwconv_valid_i  (valid_i),
    .pwconv_pixel_i  (pixel_i),
    .pwconv_weight_i (weight_i),
    .pwconv_bias_i   (bias_i),
    .pwconv_pixel_o  (pixel_o),
    .pwconv_valid_o  (valid_o)
  );

  task automatic check(input string tag, input logic [OUT_BW-1:0] got, input logic [OUT_BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected output channel k: floor((dot + bias) / 128), clamped to a signed byte.
  function automatic logic [OUT_BW-1:0] model_out(input int k);
    logic [OUT_BW-1:0] r;
    int acc, q;
    r = '0;
    for (int p = 0; p < NP; p++) begin
      acc = b_m[k];
      for (int c = 0; c < CH; c++) acc += pix_m[c][p] * w_m[k][c];
      q = (acc >= 0) ? acc / 128 : -((-acc + 127) / 128);
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      r[p*8 +: 8] = 8'(q);
    end
    return r;
  endfunction

  task automatic drive_junk();
    for (int i = 0; i < PIX_BW / 32; i++) pixel_i[i*32 +: 32] = $urandom;
    for (int i = 0; i < W_BW / 32; i++)   weight_i[i*32 +: 32] = $urandom;
    bias_i = 16'($urandom);
  endtask

  task automatic drive_filter(input int k);
    for (int c = 0; c < CH; c++) weight_i[c*8 +: 8] = 8'(w_m[k][c]);
    bias_i = 16'(b_m[k]);
  endtask

  task automatic fill(input int pv, input int wv, input int bv);
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < NP; p++) pix_m[c][p] = pv;
    for (int k = 0; k < OCH; k++) begin
      b_m[k] = bv;
      for (int c = 0; c < CH; c++) w_m[k][c] = wv;
    end
  endtask

  task automatic fill_random(input int bmax);
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < NP; p++) pix_m[c][p] = int'($urandom_range(255, 0)) - 128;
    for (int k = 0; k < OCH; k++) begin
      b_m[k] = int'($urandom_range(2 * bmax, 0)) - bmax;
      for (int c = 0; c < CH; c++) w_m[k][c] = int'($urandom_range(255, 0)) - 128;
    end
  endtask

  // abort_at > 0: pull rst_n mid-cycle after that edge and verify the job dies.
  task automatic run_job(input bit extra, input int abort_at);
    @(negedge clk);
    valid_i = 1'b1;
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < NP; p++) pixel_i[(c*NP + p)*8 +: 8] = 8'(pix_m[c][p]);
    drive_filter(0);
    @(posedge clk);
    for (int n = 1; n <= 577; n++) begin
      @(negedge clk);
      drive_junk();
      valid_i = extra && (n == 300 || n == 577);
      if (n % 18 == 0 && n / 18 < OCH) drive_filter(n / 18);
      @(posedge clk);
      #1;
      if (n >= 19 && (n - 19) % 18 == 0) begin
        exp_hold = model_out((n - 19) / 18);
        check("pulse_vld", OUT_BW'(valid_o), OUT_BW'(1));
        check("pulse_dat", pixel_o, exp_hold);
      end else begin
        check("quiet_vld", OUT_BW'(valid_o), OUT_BW'(0));
        check("hold_dat", pixel_o, exp_hold);
      end
      if (n == abort_at) break;
    end
    valid_i = 1'b0;
    if (abort_at > 0) begin
      #1 rst_n = 1'b0;
      #1;
      check("abort_vld", OUT_BW'(valid_o), OUT_BW'(0));
      check("abort_dat", pixel_o, '0);
      exp_hold = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 60; n++) begin
        @(posedge clk);
        #1;
        check("post_abort_vld", OUT_BW'(valid_o), OUT_BW'(0));
        check("post_abort_dat", pixel_o, '0);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_i  = 1'b0;
    pixel_i  = '0;
    weight_i = '0;
    bias_i   = '0;
    exp_hold = '0;
    repeat (3) @(negedge clk);
    check("reset_vld", OUT_BW'(valid_o), OUT_BW'(0));
    check("reset_dat", pixel_o, '0);
    rst_n = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      drive_junk();
      @(posedge clk);
      #1;
      check("idle_vld", OUT_BW'(valid_o), OUT_BW'(0));
      check("idle_dat", pixel_o, '0);
    end

    fill(4, 1, 0);       run_job(1'b0, 0);
    check("const4_byte", OUT_BW'(pixel_o[7:0]), OUT_BW'(8'd1));
    fill(127, 127, 0);   run_job(1'b0, 0);
    check("sat_pos_byte", OUT_BW'(pixel_o[15:8]), OUT_BW'(8'h7f));
    fill(127, -128, 0);  run_job(1'b0, 0);
    check("sat_neg_byte", OUT_BW'(pixel_o[15:8]), OUT_BW'(8'h80));
    fill(9, 0, 640);     run_job(1'b0, 0);
    check("bias640_byte", OUT_BW'(pixel_o[23:16]), OUT_BW'(8'd5));
    fill(9, 0, -1);      run_job(1'b0, 0);
    check("bias_m1_byte", OUT_BW'(pixel_o[23:16]), OUT_BW'(8'hff));

    fill(0, 1, 0);
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < NP; p++) pix_m[c][p] = p;
    run_job(1'b0, 0);
    check("ramp_byte35", OUT_BW'(pixel_o[35*8 +: 8]), OUT_BW'(8'd8));

    fill(3, 0, 0);
    for (int k = 0; k < OCH; k++)
      for (int c = 0; c < CH; c++) w_m[k][c] = k;
    run_job(1'b1, 0);
    check("kweight_last", OUT_BW'(pixel_o[7:0]), OUT_BW'(8'd23));

    fill_random(2000);   run_job(1'b0, 0);
    fill_random(32767);  run_job(1'b1, 0);
    fill_random(1000);   run_job(1'b0, 73);
    fill_random(3000);   run_job(1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
